// File: rtl/data_mem_ctrl.sv
// data_mem_ctrl: handshaked DEPTH x WORD_W data memory for the MEM stage.
// Serves one-beat (single word) or two-beat (double word) accesses, with
// WAIT_STATES extra cycles per beat, range checking and a one-cycle o_done.
// Optional feature macro: DATA_MEM_PARITY_EN (per-word even parity and o_perr).
module data_mem_ctrl #(
    parameter int unsigned WORD_W      = 16,
    parameter int unsigned ADDR_W      = 20,
    parameter int unsigned DEPTH       = 1024,
    parameter int unsigned WAIT_STATES = 0
) (
    input  logic                  clk,
    input  logic                  i_rst_n,
    input  logic                  i_req,
    input  logic                  i_we,
    input  logic                  i_en32,
    input  logic [ADDR_W-1:0]     i_address,
    input  logic [2*WORD_W-1:0]   i_data_in,
    output logic                  o_ready,
    output logic                  o_done,
    output logic                  o_valid,
    output logic [2*WORD_W-1:0]   o_data_out,
    output logic                  o_err,
    output logic                  o_perr
);

    localparam int unsigned      IDX_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [ADDR_W:0]  DEPTH_A = (ADDR_W + 1)'(DEPTH);
    localparam logic [ADDR_W:0]  LAST_A  = DEPTH_A - 1'b1;
    localparam logic [3:0]       WS_LAST = 4'(WAIT_STATES);

    typedef enum logic [1:0] {
        S_IDLE,
        S_LOW,
        S_HIGH,
        S_RESP
    } state_t;

    state_t state;
    state_t state_nxt;

    // Request latched at acceptance
    logic                  we_q;
    logic                  en32_q;
    logic                  err_q;
    logic                  perr_q;
    logic [IDX_W-1:0]      addr_q;
    logic [2*WORD_W-1:0]   wdata_q;
    logic [WORD_W-1:0]     low_q;
    logic [3:0]            wait_cnt;

    // Per-beat decode
    logic                  accept;
    logic                  range_err;
    logic                  beat_last;
    logic                  beat_wr;
    logic                  beat_rd;
    logic                  par_bad;
    logic [IDX_W-1:0]      beat_idx;
    logic [WORD_W-1:0]     beat_rdata;
    logic [WORD_W-1:0]     beat_wdata;

    logic [WORD_W-1:0]     mem [DEPTH];

    // Acceptance and range check on the incoming request (no wrap-around)
    always_comb begin
        accept    = (state == S_IDLE) && i_req;
        range_err = ({1'b0, i_address} >= DEPTH_A) ||
                    (i_en32 && ({1'b0, i_address} >= LAST_A));
    end

    // Beat decode: which word is touched on the final edge of LOW/HIGH
    always_comb begin
        beat_last  = (wait_cnt == WS_LAST);
        beat_idx   = (state == S_HIGH) ? (addr_q + IDX_W'(1)) : addr_q;
        beat_wdata = (state == S_HIGH) ? wdata_q[2*WORD_W-1:WORD_W] : wdata_q[WORD_W-1:0];
        beat_rdata = mem[beat_idx];
        beat_wr    = 1'b0;
        beat_rd    = 1'b0;
        if (beat_last && (((state == S_LOW) && !err_q) || (state == S_HIGH))) begin
            beat_wr = we_q;
            beat_rd = !we_q;
        end
    end

`ifdef DATA_MEM_PARITY_EN
    logic par_mem [DEPTH];

    // Parity bit stored alongside each written word
    always_ff @(posedge clk) begin
        if (beat_wr) begin
            par_mem[beat_idx] <= ^beat_wdata;
        end
    end

    // Parity recomputed on every read beat
    always_comb begin
        par_bad = beat_rd && ((^beat_rdata) != par_mem[beat_idx]);
    end
`else
    // No parity storage in this build
    always_comb begin
        par_bad = 1'b0;
    end
`endif

    // Storage array write port; contents survive reset
    always_ff @(posedge clk) begin
        if (beat_wr) begin
            mem[beat_idx] <= beat_wdata;
        end
    end

    // State register
    always_ff @(posedge clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        unique case (state)
            S_IDLE: if (i_req) state_nxt = S_LOW;
            S_LOW: begin
                if (err_q) begin
                    state_nxt = S_RESP;
                end else if (beat_last) begin
                    state_nxt = en32_q ? S_HIGH : S_RESP;
                end
            end
            S_HIGH: if (beat_last) state_nxt = S_RESP;
            S_RESP: state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // Outputs decoded from state and the latched response flags
    always_comb begin
        o_ready = (state == S_IDLE);
        o_done  = (state == S_RESP);
        o_valid = (state == S_RESP) && !err_q && !we_q;
        o_err   = (state == S_RESP) && err_q;
        o_perr  = (state == S_RESP) && perr_q;
    end

    // Request capture, wait counter, read assembly and response flags
    always_ff @(posedge clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            we_q       <= 1'b0;
            en32_q     <= 1'b0;
            err_q      <= 1'b0;
            perr_q     <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            low_q      <= '0;
            wait_cnt   <= '0;
            o_data_out <= '0;
        end else begin
            if (accept) begin
                we_q    <= i_we;
                en32_q  <= i_en32;
                err_q   <= range_err;
                perr_q  <= 1'b0;
                addr_q  <= i_address[IDX_W-1:0];
                wdata_q <= i_data_in;
            end

            // Counter restarts whenever a beat ends or the state changes
            if (((state == S_LOW) || (state == S_HIGH)) && (state_nxt == state)) begin
                wait_cnt <= wait_cnt + 4'd1;
            end else begin
                wait_cnt <= '0;
            end

            if (par_bad) begin
                perr_q <= 1'b1;
            end

            // o_data_out changes only as a successful read enters RESP
            if (beat_rd && (state == S_LOW)) begin
                low_q <= beat_rdata;
                if (!en32_q) begin
                    o_data_out <= {{WORD_W{1'b0}}, beat_rdata};
                end
            end
            if (beat_rd && (state == S_HIGH)) begin
                o_data_out <= {beat_rdata, low_q};
            end
        end
    end

endmodule

// File: tb/tb_data_mem_ctrl.sv
// Self-checking bench for data_mem_ctrl (WAIT_STATES=3, DEPTH=1024).
// Expected results come from a word-array model of the memory and the
// latency / range rules of the controller.
module tb_data_mem_ctrl;

    localparam int WS    = 3;
    localparam int DEPTH = 1024;

    logic        clk = 1'b0;
    logic        i_rst_n;
    logic        i_req;
    logic        i_we;
    logic        i_en32;
    logic [19:0] i_address;
    logic [31:0] i_data_in;
    logic        o_ready;
    logic        o_done;
    logic        o_valid;
    logic [31:0] o_data_out;
    logic        o_err;
    logic        o_perr;

    always #5 clk = ~clk;

    data_mem_ctrl #(
        .WORD_W(16),
        .ADDR_W(20),
        .DEPTH(DEPTH),
        .WAIT_STATES(WS)
    ) dut (
        .clk(clk),
        .i_rst_n(i_rst_n),
        .i_req(i_req),
        .i_we(i_we),
        .i_en32(i_en32),
        .i_address(i_address),
        .i_data_in(i_data_in),
        .o_ready(o_ready),
        .o_done(o_done),
        .o_valid(o_valid),
        .o_data_out(o_data_out),
        .o_err(o_err),
        .o_perr(o_perr)
    );

    typedef struct {
        logic        we;
        logic        en32;
        logic [19:0] a;
        logic [31:0] d;
    } op_t;

    int errors = 0;
    int checks = 0;

    // Reference model state
    logic [15:0] ref_mem [DEPTH];
    bit          known   [DEPTH];
    logic [31:0] last_rd;

    // Observations of the most recent access
    int          r_lat;
    logic        r_valid, r_err, r_perr, r_done_after, r_ready_after;
    logic [31:0] r_dout;

    // Drive one request and record what the DUT answers
    task automatic access(input op_t op);
        int n;
        n = 0;
        @(negedge clk);
        while (!o_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        i_req = 1'b1; i_we = op.we; i_en32 = op.en32;
        i_address = op.a; i_data_in = op.d;
        @(posedge clk); #1;
        i_req = 1'b0;
        i_address = 20'($urandom());
        i_data_in = $urandom();
        r_lat = 0;
        while (!o_done && r_lat < 64) begin
            @(posedge clk); #1;
            r_lat++;
        end
        r_valid = o_valid; r_err = o_err; r_perr = o_perr; r_dout = o_data_out;
        @(posedge clk); #1;
        r_done_after  = o_done;
        r_ready_after = o_ready;
    endtask

    // Behavioural model: range rule, latency rule, word-array update
    task automatic model(input op_t op, output logic e_err, output int e_lat,
                         output logic e_valid, output logic [31:0] e_dout);
        int ai;
        ai      = int'(op.a);
        e_err   = (ai >= DEPTH) || (op.en32 && (ai + 1 >= DEPTH));
        e_lat   = e_err ? 1 : (op.en32 ? 2 * WS + 2 : WS + 1);
        e_valid = !e_err && !op.we;
        if (!e_err && op.we) begin
            ref_mem[ai] = op.d[15:0];
            known[ai]   = 1'b1;
            if (op.en32) begin
                ref_mem[ai + 1] = op.d[31:16];
                known[ai + 1]   = 1'b1;
            end
        end
        if (e_valid) begin
            last_rd = op.en32 ? {ref_mem[ai + 1], ref_mem[ai]} : {16'h0000, ref_mem[ai]};
        end
        e_dout = last_rd;
    endtask

    task automatic test_reset();
        i_rst_n = 1'b0; i_req = 1'b0; i_we = 1'b0; i_en32 = 1'b0;
        i_address = '0; i_data_in = '0;
        repeat (3) @(posedge clk);
        #1;
        checks++; if (o_ready !== 1'b1) begin errors++; $display("FAIL reset_ready got %b expected 1", o_ready); end
        checks++; if ({o_done, o_valid, o_err, o_perr} !== 4'b0000) begin
            errors++; $display("FAIL reset_flags got %b expected 0000", {o_done, o_valid, o_err, o_perr});
        end
        checks++; if (o_data_out !== 32'h0) begin errors++; $display("FAIL reset_data got %h expected 00000000", o_data_out); end
        last_rd = '0;
        @(negedge clk);
        i_rst_n = 1'b1;
    endtask

    task automatic test_words();
        op_t ops[$];
        logic e_err, e_valid; int e_lat; logic [31:0] e_dout;
        ops.push_back('{1'b1, 1'b0, 20'h010, 32'h0000BEEF});
        ops.push_back('{1'b0, 1'b0, 20'h010, 32'h0});
        ops.push_back('{1'b1, 1'b1, 20'h101, 32'h12345678});
        ops.push_back('{1'b0, 1'b1, 20'h101, 32'h0});
        ops.push_back('{1'b0, 1'b0, 20'h102, 32'h0});
        ops.push_back('{1'b0, 1'b0, 20'h101, 32'h0});
        foreach (ops[i]) begin
            access(ops[i]);
            model(ops[i], e_err, e_lat, e_valid, e_dout);
            checks++; if (r_lat !== e_lat) begin errors++; $display("FAIL words_lat[%0d] got %0d expected %0d", i, r_lat, e_lat); end
            checks++; if ({r_err, r_valid, r_perr} !== {e_err, e_valid, 1'b0}) begin
                errors++; $display("FAIL words_flags[%0d] got %b expected %b", i, {r_err, r_valid, r_perr}, {e_err, e_valid, 1'b0});
            end
            checks++; if (r_dout !== e_dout) begin errors++; $display("FAIL words_data[%0d] got %h expected %h", i, r_dout, e_dout); end
            checks++; if ({r_done_after, r_ready_after} !== 2'b01) begin
                errors++; $display("FAIL words_pulse[%0d] got done,ready=%b expected 01", i, {r_done_after, r_ready_after});
            end
        end
    endtask

    task automatic test_range();
        op_t ops[$];
        logic e_err, e_valid; int e_lat; logic [31:0] e_dout;
        ops.push_back('{1'b1, 1'b0, 20'h3FF, 32'h00007777});
        ops.push_back('{1'b0, 1'b0, 20'h3FF, 32'h0});
        ops.push_back('{1'b0, 1'b1, 20'h3FF, 32'h0});
        ops.push_back('{1'b0, 1'b0, 20'h400, 32'h0});
        ops.push_back('{1'b1, 1'b1, 20'h3FF, 32'h99998888});
        ops.push_back('{1'b1, 1'b0, 20'hFFFFF, 32'h00005A5A});
        ops.push_back('{1'b0, 1'b0, 20'h3FF, 32'h0});
        ops.push_back('{1'b1, 1'b1, 20'h3FE, 32'h44443333});
        ops.push_back('{1'b0, 1'b1, 20'h3FE, 32'h0});
        foreach (ops[i]) begin
            access(ops[i]);
            model(ops[i], e_err, e_lat, e_valid, e_dout);
            checks++; if (r_lat !== e_lat) begin errors++; $display("FAIL range_lat[%0d] got %0d expected %0d", i, r_lat, e_lat); end
            checks++; if ({r_err, r_valid, r_perr} !== {e_err, e_valid, 1'b0}) begin
                errors++; $display("FAIL range_flags[%0d] got %b expected %b", i, {r_err, r_valid, r_perr}, {e_err, e_valid, 1'b0});
            end
            checks++; if (r_dout !== e_dout) begin errors++; $display("FAIL range_data[%0d] got %h expected %h", i, r_dout, e_dout); end
        end
    endtask

    task automatic test_random();
        op_t op;
        logic e_err, e_valid; int e_lat; logic [31:0] e_dout;
        int sel, ai;
        for (int i = 0; i < 150; i++) begin
            sel     = int'($urandom_range(0, 9));
            op.en32 = 1'($urandom());
            op.we   = 1'($urandom());
            op.d    = $urandom();
            if (sel < 4)      op.a = 20'($urandom_range(0, 31));
            else if (sel < 8) op.a = 20'($urandom_range(1000, 1023));
            else              op.a = 20'($urandom_range(1024, 20'hFFFFF));
            ai = int'(op.a);
            if (!op.we && ai < DEPTH) begin
                if (!known[ai] || (op.en32 && ai + 1 < DEPTH && !known[ai + 1])) op.we = 1'b1;
            end
            access(op);
            model(op, e_err, e_lat, e_valid, e_dout);
            checks++; if (r_lat !== e_lat) begin errors++; $display("FAIL rand_lat[%0d] a=%h got %0d expected %0d", i, op.a, r_lat, e_lat); end
            checks++; if ({r_err, r_valid, r_perr} !== {e_err, e_valid, 1'b0}) begin
                errors++; $display("FAIL rand_flags[%0d] a=%h got %b expected %b", i, op.a, {r_err, r_valid, r_perr}, {e_err, e_valid, 1'b0});
            end
            checks++; if (r_dout !== e_dout) begin errors++; $display("FAIL rand_data[%0d] a=%h got %h expected %h", i, op.a, r_dout, e_dout); end
        end
    endtask

    task automatic test_back_to_back();
        op_t op;
        logic e_err, e_valid; int e_lat; logic [31:0] e_dout;
        int dones, ready_low, n;
        n = 0;
        @(negedge clk);
        while (!o_ready && n < 50) begin @(negedge clk); n++; end
        i_req = 1'b1; i_we = 1'b1; i_en32 = 1'b1; i_address = 20'h040; i_data_in = 32'hCAFEF00D;
        @(posedge clk); #1;
        dones = 0; ready_low = 0;
        if (!o_ready) ready_low++;
        if (o_done) dones++;
        i_address = 20'h041; i_data_in = 32'h11111111;
        for (int c = 1; c <= 2 * WS + 6; c++) begin
            @(posedge clk); #1;
            if (!o_ready) ready_low++;
            if (o_done) dones++;
            if (c == 2 * WS + 2) i_req = 1'b0;
        end
        checks++; if (dones !== 1) begin errors++; $display("FAIL b2b_dones got %0d expected 1", dones); end
        checks++; if (ready_low !== 2 * WS + 3) begin errors++; $display("FAIL b2b_busy got %0d expected %0d", ready_low, 2 * WS + 3); end
        model('{1'b1, 1'b1, 20'h040, 32'hCAFEF00D}, e_err, e_lat, e_valid, e_dout);
        op = '{1'b0, 1'b1, 20'h040, 32'h0};
        access(op);
        model(op, e_err, e_lat, e_valid, e_dout);
        checks++; if (r_dout !== e_dout) begin errors++; $display("FAIL b2b_data got %h expected %h", r_dout, e_dout); end
        op = '{1'b0, 1'b0, 20'h042, 32'h0};
        if (known[66]) begin
            access(op);
            model(op, e_err, e_lat, e_valid, e_dout);
            checks++; if (r_dout !== e_dout) begin errors++; $display("FAIL b2b_dropped got %h expected %h", r_dout, e_dout); end
        end
    endtask

    task automatic test_reset_mid();
        op_t op;
        logic e_err, e_valid; int e_lat; logic [31:0] e_dout;
        int dones, n;
        op = '{1'b1, 1'b1, 20'h020, 32'h11112222};
        access(op);
        model(op, e_err, e_lat, e_valid, e_dout);
        n = 0;
        @(negedge clk);
        while (!o_ready && n < 50) begin @(negedge clk); n++; end
        i_req = 1'b1; i_we = 1'b1; i_en32 = 1'b1; i_address = 20'h020; i_data_in = 32'hAAAA5555;
        @(posedge clk); #1;
        i_req = 1'b0;
        repeat (WS + 1) @(posedge clk);
        @(negedge clk);
        i_rst_n = 1'b0;
        #1;
        checks++; if ({o_ready, o_done, o_valid, o_err, o_perr} !== 5'b10000) begin
            errors++; $display("FAIL midrst_flags got %b expected 10000", {o_ready, o_done, o_valid, o_err, o_perr});
        end
        checks++; if (o_data_out !== 32'h0) begin errors++; $display("FAIL midrst_data got %h expected 00000000", o_data_out); end
        @(negedge clk);
        i_rst_n = 1'b1;
        dones = 0;
        for (int c = 0; c < 2 * WS + 4; c++) begin
            @(posedge clk); #1;
            if (o_done) dones++;
        end
        checks++; if (dones !== 0) begin errors++; $display("FAIL midrst_nodone got %0d expected 0", dones); end
        ref_mem[32] = 16'h5555;
        last_rd = '0;
        op = '{1'b0, 1'b0, 20'h020, 32'h0};
        access(op);
        model(op, e_err, e_lat, e_valid, e_dout);
        checks++; if (r_dout !== e_dout) begin errors++; $display("FAIL midrst_low got %h expected %h", r_dout, e_dout); end
        op = '{1'b0, 1'b0, 20'h021, 32'h0};
        access(op);
        model(op, e_err, e_lat, e_valid, e_dout);
        checks++; if (r_dout !== e_dout) begin errors++; $display("FAIL midrst_high got %h expected %h", r_dout, e_dout); end
    endtask

    task automatic test_parity();
        op_t op;
        logic e_err, e_valid, e_perr; int e_lat; logic [31:0] e_dout;
        op = '{1'b1, 1'b0, 20'h005, 32'h000000F0};
        access(op);
        model(op, e_err, e_lat, e_valid, e_dout);
`ifdef DATA_MEM_PARITY_EN
        dut.par_mem[5] = ~dut.par_mem[5];
        e_perr = 1'b1;
`else
        e_perr = 1'b0;
`endif
        op = '{1'b0, 1'b0, 20'h005, 32'h0};
        access(op);
        model(op, e_err, e_lat, e_valid, e_dout);
        checks++; if ({r_valid, r_perr, r_err} !== {1'b1, e_perr, 1'b0}) begin
            errors++; $display("FAIL parity_flags got %b expected %b", {r_valid, r_perr, r_err}, {1'b1, e_perr, 1'b0});
        end
        checks++; if (r_dout !== 32'h000000F0) begin errors++; $display("FAIL parity_data got %h expected 000000f0", r_dout); end
    endtask

    initial begin
        foreach (known[i]) known[i] = 1'b0;
        test_reset();
        test_words();
        test_range();
        test_back_to_back();
        test_reset_mid();
        test_random();
        test_parity();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
